// File: rtl/legv8_fetch_queue.sv
// legv8_fetch_queue: instruction-fetch front end for the LEGv8 core.
// Owns the fetch PC, issues one word read at a time to instruction memory
// (req/ack), buffers returned words tagged with their PC in a small FIFO and
// hands them to the control unit over valid/ready. A redirect flushes the
// queue and restarts fetch; a request already in flight is waited out in
// DROP so its data never enters the queue.
// Optional build macro FETCH_PERF_EN adds saturating fetch/flush counters.
module legv8_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clock,
    input  logic        RST,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [15:0] perf_flushes
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic [31:0]   pend_pc, pend_pc_nxt;
    logic [31:0]   redir_tgt;

    entry_t        fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count, count_nxt;

    logic          ack_live;
    logic          push;
    logic          pop;

    // Word-aligned redirect target; the low two bits are not part of the PC.
    assign redir_tgt = {redirect_pc[31:2], 2'b00};

    // A request is outstanding in REQ and DROP; the address is the fetch PC,
    // which only moves on an ack, so it stays stable while a request waits.
    assign imem_req  = (state != IDLE);
    assign imem_addr = fetch_pc;
    assign ack_live  = imem_req & imem_ack;

    // Redirect hides the head immediately so nothing stale is consumed.
    assign instr_valid = (count != '0) & ~redirect;
    assign pop         = instr_valid & instr_ready;
    // Only a live REQ ack delivers a usable word; DROP acks are stale.
    assign push        = (state == REQ) & ack_live & ~redirect;

    assign instr    = fifo_mem[rd_ptr].word;
    assign instr_pc = fifo_mem[rd_ptr].pc;

    // Occupancy after this edge, used both for the FIFO and for issue gating.
    always_comb begin
        count_nxt = count;
        if (redirect)
            count_nxt = '0;
        else
            count_nxt = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

    // Fetch FSM: next state, next fetch PC and pending redirect target.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pend_pc_nxt  = pend_pc;
        case (state)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_nxt = redir_tgt;
                    state_nxt    = REQ;
                end else if (count_nxt < DEPTH_C) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    if (ack_live) begin
                        // Request completes now; its data is dropped by the flush.
                        fetch_pc_nxt = redir_tgt;
                        state_nxt    = REQ;
                    end else begin
                        // Address must stay put until the ack, so park the target.
                        pend_pc_nxt = redir_tgt;
                        state_nxt   = DROP;
                    end
                end else if (ack_live) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    state_nxt    = (count_nxt < DEPTH_C) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (ack_live) begin
                    fetch_pc_nxt = redirect ? redir_tgt : pend_pc;
                    state_nxt    = REQ;
                end else if (redirect) begin
                    pend_pc_nxt = redir_tgt;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, fetch PC and pending target registers.
    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            pend_pc  <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            pend_pc  <= pend_pc_nxt;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue outright.
    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero.
    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(DEPTH); i++)
                fifo_mem[i] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr] <= '{pc: fetch_pc, word: imem_rdata};
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating counters of delivered instructions and redirect cycles.
    always_ff @(posedge clock or posedge RST) begin
        if (RST) begin
            perf_fetched <= '0;
            perf_flushes <= '0;
        end else begin
            if (push && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (redirect && (perf_flushes != '1))
                perf_flushes <= perf_flushes + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_legv8_fetch_queue.sv
// tb_legv8_fetch_queue: directed bench for the fetch queue with a small
// instruction-memory model of selectable latency (0 = ack with request).
module tb_legv8_fetch_queue;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clock;
    logic        RST;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [15:0] perf_flushes;
`endif

    int checks   = 0;
    int failures = 0;

    logic [1:0]  lat;
    logic [3:0]  wait_cnt;

    legv8_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .RST         (RST),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushes(perf_flushes)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: acks after 'lat' waiting cycles; ROM word = addr ^ KEY.
    assign imem_ack   = imem_req && (wait_cnt >= {2'b00, lat});
    assign imem_rdata = imem_addr ^ KEY;

    always @(posedge clock or posedge RST) begin
        if (RST)                       wait_cnt <= '0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 4'd1;
        else                           wait_cnt <= '0;
    end

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Pulse reset; returns #1 after a rising edge with RST low (cycle 0).
    task automatic do_reset();
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        RST         = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1 RST = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic        rst_before;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    localparam int NV = 20;
    vec_t tv [NV];

    logic [31:0] wrap_exp [4];
    int          n;
    bit          done;

    initial begin
        // Zero-wait streaming, ready always high.
        tv[0]  = '{1'b1, 1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 32'd4,  1'b1, 32'd0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 32'd8,  1'b1, 32'd4};
        tv[4]  = '{1'b0, 1'b1, 1'b1, 32'd12, 1'b1, 32'd8};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd12};
        tv[6]  = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd16};
        // Back-pressure: fill to 4, request stops, then drain and resume at 16.
        tv[7]  = '{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
        tv[8]  = '{1'b0, 1'b0, 1'b1, 32'd0,  1'b0, 32'd0};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 32'd4,  1'b1, 32'd0};
        tv[10] = '{1'b0, 1'b0, 1'b1, 32'd8,  1'b1, 32'd0};
        tv[11] = '{1'b0, 1'b0, 1'b1, 32'd12, 1'b1, 32'd0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        tv[13] = '{1'b0, 1'b0, 1'b0, 32'd16, 1'b1, 32'd0};
        tv[14] = '{1'b0, 1'b1, 1'b0, 32'd16, 1'b1, 32'd0};
        tv[15] = '{1'b0, 1'b1, 1'b1, 32'd16, 1'b1, 32'd4};
        tv[16] = '{1'b0, 1'b1, 1'b1, 32'd20, 1'b1, 32'd8};
        tv[17] = '{1'b0, 1'b1, 1'b1, 32'd24, 1'b1, 32'd12};
        tv[18] = '{1'b0, 1'b1, 1'b1, 32'd28, 1'b1, 32'd16};
        tv[19] = '{1'b0, 1'b1, 1'b1, 32'd32, 1'b1, 32'd20};

        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;

        lat         = 2'd0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;

        // Reset state.
        RST = 1'b1;
        @(negedge clock);
        chk_b("rst_req",      imem_req,    1'b0);
        chk_w("rst_addr",     imem_addr,   32'h0);
        chk_b("rst_valid",    instr_valid, 1'b0);
        chk_w("rst_instr",    instr,       32'h0);
        chk_w("rst_instr_pc", instr_pc,    32'h0);

        // Table-driven streaming and back-pressure.
        for (int i = 0; i < NV; i++) begin
            if (tv[i].rst_before) do_reset();
            instr_ready = tv[i].ready;
            @(negedge clock);
            chk_b($sformatf("vec%0d_req", i),   imem_req,    tv[i].exp_req);
            chk_w($sformatf("vec%0d_addr", i),  imem_addr,   tv[i].exp_addr);
            chk_b($sformatf("vec%0d_valid", i), instr_valid, tv[i].exp_valid);
            if (tv[i].exp_valid) begin
                chk_w($sformatf("vec%0d_pc", i),    instr_pc, tv[i].exp_pc);
                chk_w($sformatf("vec%0d_instr", i), instr,    tv[i].exp_pc ^ KEY);
            end
            next_cycle();
        end

        // Redirect while a slow request to PC 8 is pending.
        lat         = 2'd2;
        instr_ready = 1'b1;
        do_reset();
        done = 1'b0;
        for (int c = 0; c < 30 && !done; c++) begin
            @(negedge clock);
            if (imem_req && imem_addr == 32'h8) done = 1'b1;
            next_cycle();
        end
        chk_b("drop_reach_pc8", done, 1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        @(negedge clock);
        chk_b("drop_redir_valid", instr_valid, 1'b0);
        chk_w("drop_redir_addr",  imem_addr,   32'h8);
        next_cycle();
        redirect = 1'b0;
        @(negedge clock);
        chk_b("drop_hold_req",   imem_req,    1'b1);
        chk_w("drop_hold_addr",  imem_addr,   32'h8);
        chk_b("drop_hold_valid", instr_valid, 1'b0);
        next_cycle();
        @(negedge clock);
        chk_w("drop_new_addr", imem_addr, 32'h100);
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (instr_valid) begin
                chk_w("drop_first_pc",    instr_pc, 32'h100);
                chk_w("drop_first_instr", instr,    32'h100 ^ KEY);
                done = 1'b1;
            end else begin
                next_cycle();
                @(negedge clock);
            end
        end
        chk_b("drop_valid_seen", done, 1'b1);

        // Redirect coincident with ack and ready, two entries queued.
        lat         = 2'd0;
        instr_ready = 1'b0;
        do_reset();
        repeat (3) next_cycle();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clock);
        chk_b("coinc_valid", instr_valid, 1'b0);
        next_cycle();
        redirect = 1'b0;
        @(negedge clock);
        chk_b("coinc_empty", instr_valid, 1'b0);
        chk_b("coinc_req",   imem_req,    1'b1);
        chk_w("coinc_addr",  imem_addr,   32'h200);
        next_cycle();
        @(negedge clock);
        chk_b("coinc_valid2", instr_valid, 1'b1);
        chk_w("coinc_pc2",    instr_pc,    32'h200);
        next_cycle();
        @(negedge clock);
        chk_w("coinc_pc3",    instr_pc,    32'h204);

        // PC wrap after redirect near the top of the address space.
        do_reset();
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFB;
        next_cycle();
        redirect = 1'b0;
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            @(negedge clock);
            if (instr_valid) begin
                chk_w($sformatf("wrap_pc%0d", n), instr_pc, wrap_exp[n]);
                n++;
            end
            next_cycle();
        end
        chk_b("wrap_count", (n == 4), 1'b1);

        // Reset in the middle of a request.
        do_reset();
        instr_ready = 1'b1;
        repeat (2) next_cycle();
        @(negedge clock);
        chk_b("midrst_pre_valid", instr_valid, 1'b1);
        #1 RST = 1'b1;
        #1;
        chk_b("midrst_req",   imem_req,    1'b0);
        chk_b("midrst_valid", instr_valid, 1'b0);
        chk_w("midrst_addr",  imem_addr,   32'h0);
        chk_w("midrst_pc",    instr_pc,    32'h0);
        @(posedge clock);
        #1 RST = 1'b0;
`ifdef FETCH_PERF_EN
        chk_w("perf_fetched_rst", perf_fetched, 32'd0);
        chk_w("perf_flushes_rst", {16'h0, perf_flushes}, 32'd0);
`endif
        repeat (2) next_cycle();
        @(negedge clock);
        chk_b("restart_valid", instr_valid, 1'b1);
        chk_w("restart_pc",    instr_pc,    32'h0);
`ifdef FETCH_PERF_EN
        repeat (4) next_cycle();
        chk_w("perf_fetched_5", perf_fetched, 32'd5);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        next_cycle();
        redirect = 1'b0;
        chk_w("perf_flushes_1", {16'h0, perf_flushes}, 32'd1);
        chk_w("perf_fetched_hold", perf_fetched, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
